jogao_da_velha_top: RTL and testbench

//  Ultimate tic-tac-toe ("jogao da velha") controller: 9 macro boards x 9 micro cells, two players.

---
 rtl/jogao_pkg.sv | 49 ++++
 rtl/hex7seg.sv | 28 ++
 rtl/verifica_linha3x3.sv | 26 ++
 rtl/jogao_da_velha_top.sv | 192 +++++++++++++++++++
 tb/tb_jogao_da_velha_top.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/jogao_pkg.sv
// rtl/jogao_pkg.sv - shared state codes, cell codes, win lines and helpers for jogao da velha
package jogao_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    PREPARA      = 4'h1,
    ESPERA_MACRO = 4'h2,
    VALIDA_MACRO = 4'h3,
    ESPERA_MICRO = 4'h4,
    VALIDA_MICRO = 4'h5,
    CHECA_MACRO  = 4'h6,
    CHECA_JOGO   = 4'h7,
    TROCA        = 4'h8,
    FIM          = 4'hF
  } estado_t;

  localparam logic [1:0] VAZIO  = 2'b00;
  localparam logic [1:0] J1     = 2'b01;
  localparam logic [1:0] J2     = 2'b10;
  localparam logic [1:0] EMPATE = 2'b11;

  // Zero-based cell indices of the 8 lines: rows, columns, diagonals
  localparam logic [7:0][2:0][3:0] LINHAS = {
    {4'd2, 4'd4, 4'd6}, {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8}, {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6}, {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5}, {4'd0, 4'd1, 4'd2}
  };

  // Returns {exactly_one_hot, zero-based index of the set bit}
  function automatic logic [4:0] decodifica(input logic [8:0] b);
    logic [3:0] idx;
    logic       ok;
    idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (b[i]) idx = 4'(i);
    end
    ok = (b != 9'd0) && ((b & (b - 9'd1)) == 9'd0);
    return {ok, idx};
  endfunction

  // First board-memory slot of a 1-based macro number (0 maps to macro 1)
  function automatic logic [6:0] base_macro(input logic [3:0] m);
    logic [3:0] mi;
    mi = (m == 4'd0) ? 4'd0 : m - 4'd1;
    return {mi, 3'b000} + {3'b000, mi};
  endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - hex digit to active-low 7-segment {g,f,e,d,c,b,a}
module hex7seg (
  input  logic [3:0] valor,
  output logic [6:0] seg
);

  always_comb begin
    case (valor)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/verifica_linha3x3.sv
// rtl/verifica_linha3x3.sv - 3x3 line check for one player plus board-full flag
module verifica_linha3x3 import jogao_pkg::*; (
  input  logic [17:0] celulas,
  input  logic [1:0]  jogador,
  output logic        vitoria,
  output logic        cheio
);

  logic [8:0][1:0] c;

  always_comb begin
    c       = celulas;
    vitoria = 1'b0;
    cheio   = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (c[LINHAS[l][0]] == jogador && c[LINHAS[l][1]] == jogador &&
          c[LINHAS[l][2]] == jogador) begin
        vitoria = 1'b1;
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (c[i] == VAZIO) cheio = 1'b0;
    end
  end

endmodule

// File: rtl/jogao_da_velha_top.sv
// rtl/jogao_da_velha_top.sv - ultimate tic-tac-toe controller: FSM, 81-cell board, win checks, displays
module jogao_da_velha_top import jogao_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [8:0] botoes,
  output logic [8:0] leds,
  output logic       pronto,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       db_tem_jogada,
  output logic [6:0] db_macro,
  output logic [6:0] db_micro,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogador,
  output logic [6:0] db_J,
  output logic       s_out
);

  estado_t          estado_q, estado_d;
  logic             jogador_q, jogador_d;
  logic [3:0]       macro_q, macro_d;
  logic [3:0]       micro_q, micro_d;
  logic [80:0][1:0] cells_q, cells_d;
  logic [8:0][1:0]  status_q, status_d;
  logic [8:0]       botoes_q, botoes_d;
  logic             prev_q, prev_d;
  logic             tem_q, tem_d;
  logic             s_out_q, s_out_d;
  logic [8:0]       leds_q, leds_d;
  logic             pronto_q, pronto_d;
  logic             jogar_macro_q, jogar_macro_d;
  logic             jogar_micro_q, jogar_micro_d;

  logic        tem_jogada;
  logic [4:0]  sel;
  logic [6:0]  base_q, base_d;
  logic [3:0]  mi_q;
  logic [1:0]  codigo;
  logic [17:0] celulas_macro;
  logic        vit_macro, cheio_macro, vit_jogo, cheio_jogo;

  assign tem_jogada = (|botoes) & ~prev_q;
  assign sel        = decodifica(botoes_q);
  assign base_q     = base_macro(macro_q);
  assign mi_q       = (macro_q == 4'd0) ? 4'd0 : macro_q - 4'd1;
  assign codigo     = jogador_q ? J2 : J1;

  always_comb begin
    celulas_macro = '0;
    for (int k = 0; k < 9; k++) begin
      celulas_macro[2*k +: 2] = cells_q[base_q + 7'(k)];
    end
  end

  verifica_linha3x3 u_macro (
    .celulas (celulas_macro),
    .jogador (codigo),
    .vitoria (vit_macro),
    .cheio   (cheio_macro)
  );

  // Draw-status macros never equal a player code, so they cannot form a game line
  verifica_linha3x3 u_jogo (
    .celulas (status_q),
    .jogador (codigo),
    .vitoria (vit_jogo),
    .cheio   (cheio_jogo)
  );

  always_comb begin
    estado_d  = estado_q;
    jogador_d = jogador_q;
    macro_d   = macro_q;
    micro_d   = micro_q;
    cells_d   = cells_q;
    status_d  = status_q;
    botoes_d  = botoes;
    prev_d    = |botoes;
    tem_d     = tem_jogada;
    s_out_d   = 1'b0;

    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        cells_d   = '0;
        status_d  = '0;
        jogador_d = 1'b0;
        macro_d   = 4'd0;
        micro_d   = 4'd0;
        estado_d  = ESPERA_MACRO;
      end
      ESPERA_MACRO: if (tem_jogada) estado_d = VALIDA_MACRO;
      VALIDA_MACRO: begin
        if (sel[4] && status_q[sel[3:0]] == VAZIO) begin
          macro_d  = sel[3:0] + 4'd1;
          estado_d = ESPERA_MICRO;
        end else begin
          estado_d = ESPERA_MACRO;
        end
      end
      ESPERA_MICRO: if (tem_jogada) estado_d = VALIDA_MICRO;
      VALIDA_MICRO: begin
        if (sel[4] && cells_q[base_q + {3'b000, sel[3:0]}] == VAZIO) begin
          cells_d[base_q + {3'b000, sel[3:0]}] = codigo;
          micro_d  = sel[3:0] + 4'd1;
          estado_d = CHECA_MACRO;
        end else begin
          estado_d = ESPERA_MICRO;
        end
      end
      CHECA_MACRO: begin
        if (vit_macro) begin
          status_d[mi_q] = codigo;
          s_out_d        = 1'b1;
        end else if (cheio_macro) begin
          status_d[mi_q] = EMPATE;
        end
        estado_d = CHECA_JOGO;
      end
      CHECA_JOGO: estado_d = (vit_jogo || cheio_jogo) ? FIM : TROCA;
      TROCA: begin
        jogador_d = ~jogador_q;
        macro_d   = micro_q;
        estado_d  = (status_q[micro_q - 4'd1] == VAZIO) ? ESPERA_MICRO : ESPERA_MACRO;
      end
      FIM: if (iniciar) estado_d = PREPARA;
      default: estado_d = INICIAL;
    endcase

    pronto_d      = (estado_d == FIM);
    jogar_macro_d = (estado_d == ESPERA_MACRO);
    jogar_micro_d = (estado_d == ESPERA_MICRO);
    base_d        = base_macro(macro_d);
    leds_d        = '0;
    for (int k = 0; k < 9; k++) begin
      if (estado_d == ESPERA_MICRO || estado_d == VALIDA_MICRO) begin
        leds_d[k] = (cells_d[base_d + 7'(k)] != VAZIO);
      end else begin
        leds_d[k] = (status_d[k] != VAZIO);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= INICIAL;
      jogador_q     <= 1'b0;
      macro_q       <= 4'd0;
      micro_q       <= 4'd0;
      cells_q       <= '0;
      status_q      <= '0;
      botoes_q      <= '0;
      prev_q        <= 1'b0;
      tem_q         <= 1'b0;
      s_out_q       <= 1'b0;
      leds_q        <= '0;
      pronto_q      <= 1'b0;
      jogar_macro_q <= 1'b0;
      jogar_micro_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      jogador_q     <= jogador_d;
      macro_q       <= macro_d;
      micro_q       <= micro_d;
      cells_q       <= cells_d;
      status_q      <= status_d;
      botoes_q      <= botoes_d;
      prev_q        <= prev_d;
      tem_q         <= tem_d;
      s_out_q       <= s_out_d;
      leds_q        <= leds_d;
      pronto_q      <= pronto_d;
      jogar_macro_q <= jogar_macro_d;
      jogar_micro_q <= jogar_micro_d;
    end
  end

  assign leds          = leds_q;
  assign pronto        = pronto_q;
  assign jogar_macro   = jogar_macro_q;
  assign jogar_micro   = jogar_micro_q;
  assign db_tem_jogada = tem_q;
  assign s_out         = s_out_q;
  assign db_J          = 7'b1100001;

  hex7seg u_hex_macro   (.valor(macro_q),                      .seg(db_macro));
  hex7seg u_hex_micro   (.valor(micro_q),                      .seg(db_micro));
  hex7seg u_hex_estado  (.valor(estado_q),                     .seg(db_estado));
  hex7seg u_hex_jogador (.valor(jogador_q ? 4'd2 : 4'd1),      .seg(db_jogador));

endmodule

// File: tb/tb_jogao_da_velha_top.sv
// tb/tb_jogao_da_velha_top.sv - directed self-checking bench for jogao_da_velha_top
module tb_jogao_da_velha_top;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, GF = 7'h0E, GJ = 7'h61;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [8:0] botoes = 9'd0;
  logic [8:0] leds;
  logic       pronto, jogar_macro, jogar_micro, db_tem_jogada, s_out;
  logic [6:0] db_macro, db_micro, db_estado, db_jogador, db_J;

  int checks = 0;
  int errors = 0;
  int s_cnt = 0;
  int tem_cnt = 0;
  int s0, t0;

  jogao_da_velha_top dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .leds(leds), .pronto(pronto), .jogar_macro(jogar_macro), .jogar_micro(jogar_micro),
    .db_tem_jogada(db_tem_jogada), .db_macro(db_macro), .db_micro(db_micro),
    .db_estado(db_estado), .db_jogador(db_jogador), .db_J(db_J), .s_out(s_out)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (s_out) s_cnt++;
    if (db_tem_jogada) tem_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] pos(input int n);
    logic [8:0] one;
    one = 9'd1;
    return one << (n - 1);
  endfunction

  task automatic press(input logic [8:0] b);
    @(negedge clock);
    botoes = b;
    repeat (20) @(negedge clock);
    botoes = 9'd0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_estado", db_estado, G0);
    chk("rst_pronto", pronto, 0);
    chk("rst_leds", leds, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_estado", db_estado, G0);
    chk("idle_jmacro", jogar_macro, 0);
    chk("idle_jmicro", jogar_micro, 0);
    chk("idle_sout", s_out, 0);
    chk("idle_tem", db_tem_jogada, 0);
    chk("idle_jogador", db_jogador, G1);
    chk("idle_macro", db_macro, G0);
    chk("idle_micro", db_micro, G0);
    chk("glyph_J", db_J, GJ);

    iniciar = 1'b1;
    repeat (5) @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    chk("start_estado", db_estado, G2);
    chk("start_jmacro", jogar_macro, 1);
    chk("start_jogador", db_jogador, G1);

    t0 = tem_cnt;
    press(pos(5));
    chk("held_one_pulse", tem_cnt - t0, 1);
    chk("m5_estado", db_estado, G4);
    chk("m5_jmicro", jogar_micro, 1);
    chk("m5_jmacro", jogar_macro, 0);
    chk("m5_macro", db_macro, G5);
    chk("m5_leds", leds, 9'h000);

    press(pos(1));
    chk("p1_jogador", db_jogador, G2);
    chk("p1_macro", db_macro, G1);
    chk("p1_micro", db_micro, G1);
    press(pos(5));
    chk("p2_jogador", db_jogador, G1);
    chk("p2_leds", leds, 9'h001);
    press(pos(2));
    chk("p3_macro", db_macro, G2);
    press(pos(5));
    chk("p4_leds", leds, 9'h003);

    s0 = s_cnt;
    press(pos(3));
    chk("win_m5_sout", s_cnt - s0, 1);
    chk("win_m5_estado", db_estado, G4);
    chk("win_m5_jogador", db_jogador, G2);
    chk("win_m5_macro", db_macro, G3);
    chk("win_m5_leds", leds, 9'h000);

    press(pos(5));
    chk("free_estado", db_estado, G2);
    chk("free_jmacro", jogar_macro, 1);
    chk("free_jogador", db_jogador, G1);
    chk("free_leds", leds, 9'h010);
    press(pos(5));
    chk("rej_macro_estado", db_estado, G2);
    chk("rej_macro_jogador", db_jogador, G1);
    press(pos(1));
    chk("acc_macro_estado", db_estado, G4);
    chk("acc_macro_macro", db_macro, G1);
    chk("acc_macro_leds", leds, 9'h010);
    press(pos(5));
    chk("rej_micro_estado", db_estado, G4);
    chk("rej_micro_jogador", db_jogador, G1);
    chk("rej_micro_micro", db_micro, G5);
    press(pos(1));
    chk("acc_micro_jogador", db_jogador, G2);
    chk("acc_micro_estado", db_estado, G4);
    chk("acc_micro_leds", leds, 9'h011);

    press(pos(4)); press(pos(9)); press(pos(1)); press(pos(2)); press(pos(1));
    s0 = s_cnt;
    press(pos(3));
    chk("win_m1_sout", s_cnt - s0, 1);
    chk("win_m1_macro", db_macro, G3);
    chk("win_m1_jogador", db_jogador, G2);
    press(pos(2)); press(pos(7)); press(pos(2)); press(pos(8)); press(pos(2));
    s0 = s_cnt;
    press(pos(9));
    chk("win_m2_sout", s_cnt - s0, 1);
    press(pos(3));
    press(pos(1));
    chk("p2free_estado", db_estado, G2);
    chk("p2free_jogador", db_jogador, G2);
    chk("p2free_leds", leds, 9'h013);
    press(pos(4)); press(pos(3)); press(pos(4)); press(pos(1));
    chk("p1free_estado", db_estado, G2);
    chk("p1free_jogador", db_jogador, G1);
    s0 = s_cnt;
    press(pos(3)); press(pos(7));
    chk("fim_sout", s_cnt - s0, 1);
    chk("fim_estado", db_estado, GF);
    chk("fim_pronto", pronto, 1);
    chk("fim_jmacro", jogar_macro, 0);
    chk("fim_leds", leds, 9'h017);

    iniciar = 1'b1;
    repeat (3) @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    chk("restart_estado", db_estado, G2);
    chk("restart_leds", leds, 9'h000);
    chk("restart_pronto", pronto, 0);
    chk("restart_jogador", db_jogador, G1);
    chk("restart_macro", db_macro, G0);

    t0 = tem_cnt;
    press(pos(5));
    chk("held2_one_pulse", tem_cnt - t0, 1);
    chk("held2_estado", db_estado, G4);
    press(9'b000000011);
    chk("multi_estado", db_estado, G4);
    chk("multi_micro", db_micro, G0);
    chk("multi_leds", leds, 9'h000);

    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_estado", db_estado, G0);
    chk("async_rst_jmicro", jogar_micro, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
